// File: rtl/control_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the microcoded control sequencer: opcode values,
// FSM state encoding, T-state width/values, control-word bit indices, and
// the per-opcode instruction length helper.
// ---------------------------------------------------------------------------
package control_sequencer_pkg;

    // Opcodes (IR[7:4]); 9..D are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;
    localparam step_t T0 = 3'd0;
    localparam step_t T1 = 3'd1;
    localparam step_t T2 = 3'd2;
    localparam step_t T3 = 3'd3;
    localparam step_t T4 = 3'd4;

    // Control-word bit positions.
    localparam int C_PC_OE    = 0;
    localparam int C_PC_INC   = 1;
    localparam int C_PC_JMP   = 2;
    localparam int C_MAR_IN   = 3;
    localparam int C_RAM_OE   = 4;
    localparam int C_RAM_WE   = 5;
    localparam int C_IR_IN    = 6;
    localparam int C_IR_OE    = 7;
    localparam int C_A_IN     = 8;
    localparam int C_A_OE     = 9;
    localparam int C_B_IN     = 10;
    localparam int C_ALU_OE   = 11;
    localparam int C_ALU_SUB  = 12;
    localparam int C_FLAGS_IN = 13;
    localparam int C_OUT_IN   = 14;
    localparam int NUM_CTRL   = 15;

    typedef logic [NUM_CTRL-1:0] ctrl_t;

    // Final T-state of each instruction; the step counter wraps to T0 after it.
    function automatic step_t last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                                 return T3;
            OP_ADD, OP_SUB:                                 return T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   return T2;
            default:                                        return T1;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Bundle between the sequencer and the datapath.
//   master (sequencer): inputs run/opcode/flag_c/flag_z, drives all controls,
//                       halt and step.
//   slave  (datapath) : the mirror image.
// ---------------------------------------------------------------------------
interface control_sequencer_if;
    logic       run;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic       pc_oe, pc_inc, pc_jmp;
    logic       mar_in;
    logic       ram_oe, ram_we;
    logic       ir_in, ir_oe;
    logic       a_in, a_oe, b_in;
    logic       alu_oe, alu_sub;
    logic       flags_in, out_in;
    logic       halt;
    logic [control_sequencer_pkg::STEP_W-1:0] step;

    modport master (
        input  run, opcode, flag_c, flag_z,
        output pc_oe, pc_inc, pc_jmp, mar_in, ram_oe, ram_we, ir_in, ir_oe,
               a_in, a_oe, b_in, alu_oe, alu_sub, flags_in, out_in, halt, step
    );

    modport slave (
        output run, opcode, flag_c, flag_z,
        input  pc_oe, pc_inc, pc_jmp, mar_in, ram_oe, ram_we, ir_in, ir_oe,
               a_in, a_oe, b_in, alu_oe, alu_sub, flags_in, out_in, halt, step
    );
endinterface

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational microcode ROM.
//   state, step, opcode, flag_c, flag_z : current sequencer context
//   ctrl    : control word (bit indices from the package)
//   last    : current T-state is the final one of this instruction
//   to_halt : HLT reached its execute step; sequencer enters HALT
// Fetch (T0/T1) ignores opcode; the opcode only steers outputs from T2.
// ---------------------------------------------------------------------------
module control_decode
    import control_sequencer_pkg::*;
(
    input  state_t     state,
    input  step_t      step,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output ctrl_t      ctrl,
    output logic       last,
    output logic       to_halt
);

    always_comb begin
        ctrl    = '0;
        last    = 1'b0;
        to_halt = 1'b0;
        if (state == ST_RUN) begin
            // '>=' keeps the counter bounded even if opcode changes mid-instruction.
            last = (step >= last_step(opcode));
            case (step)
                T0: begin
                    ctrl[C_PC_OE]  = 1'b1;
                    ctrl[C_MAR_IN] = 1'b1;
                end
                T1: begin
                    ctrl[C_RAM_OE] = 1'b1;
                    ctrl[C_IR_IN]  = 1'b1;
                    ctrl[C_PC_INC] = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl[C_IR_OE]  = 1'b1;
                            ctrl[C_MAR_IN] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl[C_IR_OE] = 1'b1;
                            ctrl[C_A_IN]  = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl[C_IR_OE]  = 1'b1;
                            ctrl[C_PC_JMP] = 1'b1;
                        end
                        OP_JC: begin
                            ctrl[C_IR_OE]  = flag_c;
                            ctrl[C_PC_JMP] = flag_c;
                        end
                        OP_JZ: begin
                            ctrl[C_IR_OE]  = flag_z;
                            ctrl[C_PC_JMP] = flag_z;
                        end
                        OP_OUT: begin
                            ctrl[C_A_OE]   = 1'b1;
                            ctrl[C_OUT_IN] = 1'b1;
                        end
                        OP_HLT:  to_halt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl[C_RAM_OE] = 1'b1;
                            ctrl[C_A_IN]   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl[C_RAM_OE] = 1'b1;
                            ctrl[C_B_IN]   = 1'b1;
                        end
                        OP_STA: begin
                            ctrl[C_A_OE]   = 1'b1;
                            ctrl[C_RAM_WE] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl[C_ALU_OE]   = 1'b1;
                        ctrl[C_A_IN]     = 1'b1;
                        ctrl[C_FLAGS_IN] = 1'b1;
                        ctrl[C_ALU_SUB]  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Top-level state/T-step registers for the microcoded CPU controller.
//   clk   : rising-edge clock
//   clr_n : async active-low clear; assertion is immediate, release is
//           synchronised through two flops before the FSM may advance
//   bus   : control_sequencer_if.master (run/opcode/flags in, controls out)
// Controls are a zero-latency decode of the registered state/step.
// ---------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                clr_n,
    control_sequencer_if.master bus
);

    // Reset synchroniser: async assert, two-flop synchronous release.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    state_t state, state_nxt;
    step_t  step,  step_nxt;
    ctrl_t  ctrl;
    logic   last;
    logic   to_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= T0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            ST_IDLE: begin
                step_nxt = T0;
                if (bus.run) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (to_halt) begin
                    state_nxt = ST_HALT;
                    step_nxt  = T0;
                end else if (last) begin
                    step_nxt = T0;
                end else begin
                    step_nxt = step_t'(step + 3'd1);
                end
            end
            ST_HALT: begin
                // Sticky until clr_n; run is ignored.
                step_nxt = T0;
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = T0;
            end
        endcase
    end

    control_decode u_decode (
        .state   (state),
        .step    (step),
        .opcode  (bus.opcode),
        .flag_c  (bus.flag_c),
        .flag_z  (bus.flag_z),
        .ctrl    (ctrl),
        .last    (last),
        .to_halt (to_halt)
    );

    assign bus.pc_oe    = ctrl[C_PC_OE];
    assign bus.pc_inc   = ctrl[C_PC_INC];
    assign bus.pc_jmp   = ctrl[C_PC_JMP];
    assign bus.mar_in   = ctrl[C_MAR_IN];
    assign bus.ram_oe   = ctrl[C_RAM_OE];
    assign bus.ram_we   = ctrl[C_RAM_WE];
    assign bus.ir_in    = ctrl[C_IR_IN];
    assign bus.ir_oe    = ctrl[C_IR_OE];
    assign bus.a_in     = ctrl[C_A_IN];
    assign bus.a_oe     = ctrl[C_A_OE];
    assign bus.b_in     = ctrl[C_B_IN];
    assign bus.alu_oe   = ctrl[C_ALU_OE];
    assign bus.alu_sub  = ctrl[C_ALU_SUB];
    assign bus.flags_in = ctrl[C_FLAGS_IN];
    assign bus.out_in   = ctrl[C_OUT_IN];
    assign bus.halt     = (state == ST_HALT);
    assign bus.step     = (state == ST_RUN) ? step : T0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [14:0] PC_OE    = 15'h0001;
    localparam logic [14:0] PC_INC   = 15'h0002;
    localparam logic [14:0] PC_JMP   = 15'h0004;
    localparam logic [14:0] MAR_IN   = 15'h0008;
    localparam logic [14:0] RAM_OE   = 15'h0010;
    localparam logic [14:0] RAM_WE   = 15'h0020;
    localparam logic [14:0] IR_IN    = 15'h0040;
    localparam logic [14:0] IR_OE    = 15'h0080;
    localparam logic [14:0] A_IN     = 15'h0100;
    localparam logic [14:0] A_OE     = 15'h0200;
    localparam logic [14:0] B_IN     = 15'h0400;
    localparam logic [14:0] ALU_OE   = 15'h0800;
    localparam logic [14:0] ALU_SUB  = 15'h1000;
    localparam logic [14:0] FLAGS_IN = 15'h2000;
    localparam logic [14:0] OUT_IN   = 15'h4000;
    localparam logic [14:0] F0 = PC_OE | MAR_IN;
    localparam logic [14:0] F1 = RAM_OE | IR_IN | PC_INC;

    typedef struct {
        string           name;
        logic [3:0]      op;
        logic            fc;
        logic            fz;
        int              len;
        logic [4:0][14:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [14:0] ctrl_now();
        return {bus.out_in, bus.flags_in, bus.alu_sub, bus.alu_oe, bus.b_in,
                bus.a_oe, bus.a_in, bus.ir_oe, bus.ir_in, bus.ram_we,
                bus.ram_oe, bus.mar_in, bus.pc_jmp, bus.pc_inc, bus.pc_oe};
    endfunction

    function automatic vec_t mk(input string nm, input logic [3:0] op, input logic fc,
                                input logic fz, input int len, input logic [14:0] e2,
                                input logic [14:0] e3, input logic [14:0] e4);
        vec_t v;
        v.name = nm; v.op = op; v.fc = fc; v.fz = fz; v.len = len;
        v.exp = {e4, e3, e2, F1, F0};
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_quiet(input string nm, input logic exp_halt);
        check({nm, " ctrl"}, ctrl_now(), 0);
        check({nm, " step"}, bus.step, 0);
        check({nm, " halt"}, bus.halt, exp_halt);
    endtask

    // One full instruction; opcode is randomised in T0 to show fetch ignores it.
    task automatic run_vec(input vec_t v);
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            bus.run    = 1'($urandom_range(0, 1));
            bus.opcode = (c == 0) ? 4'($urandom_range(0, 15)) : v.op;
            bus.flag_c = v.fc;
            bus.flag_z = v.fz;
            #1;
            check($sformatf("%s step T%0d", v.name, c), bus.step, c);
            check($sformatf("%s ctrl T%0d", v.name, c), ctrl_now(), v.exp[c]);
            check($sformatf("%s halt T%0d", v.name, c), bus.halt, 0);
        end
    endtask

    // Advance (bounded) to the next T0 with NOP fed as opcode.
    task automatic goto_t0();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.opcode = 4'h0;
            bus.run    = 1'b0;
            #1;
            if (bus.step == 0 && ctrl_now() == F0) begin
                found = 1'b1;
                break;
            end
        end
        check("reach T0", found, 1);
    endtask

    initial begin
        logic found;
        int   drivers;
        vecs[0]  = mk("NOP",     4'h0, 0, 0, 2, 0, 0, 0);
        vecs[1]  = mk("LDA",     4'h1, 0, 0, 4, IR_OE | MAR_IN, RAM_OE | A_IN, 0);
        vecs[2]  = mk("ADD",     4'h2, 1, 1, 5, IR_OE | MAR_IN, RAM_OE | B_IN, ALU_OE | A_IN | FLAGS_IN);
        vecs[3]  = mk("SUB",     4'h3, 0, 0, 5, IR_OE | MAR_IN, RAM_OE | B_IN, ALU_OE | A_IN | FLAGS_IN | ALU_SUB);
        vecs[4]  = mk("STA",     4'h4, 0, 0, 4, IR_OE | MAR_IN, A_OE | RAM_WE, 0);
        vecs[5]  = mk("LDI",     4'h5, 0, 0, 3, IR_OE | A_IN, 0, 0);
        vecs[6]  = mk("JMP",     4'h6, 0, 0, 3, IR_OE | PC_JMP, 0, 0);
        vecs[7]  = mk("JC nt",   4'h7, 0, 1, 3, 0, 0, 0);
        vecs[8]  = mk("JC tk",   4'h7, 1, 0, 3, IR_OE | PC_JMP, 0, 0);
        vecs[9]  = mk("JZ nt",   4'h8, 1, 0, 3, 0, 0, 0);
        vecs[10] = mk("JZ tk",   4'h8, 0, 1, 3, IR_OE | PC_JMP, 0, 0);
        vecs[11] = mk("OUT",     4'hE, 0, 0, 3, A_OE | OUT_IN, 0, 0);
        vecs[12] = mk("UND B",   4'hB, 0, 0, 2, 0, 0, 0);
        vecs[13] = mk("UND 9",   4'h9, 1, 1, 2, 0, 0, 0);
        vecs[14] = mk("UND D",   4'hD, 0, 0, 2, 0, 0, 0);
        vecs[15] = mk("LDA 2",   4'h1, 1, 1, 4, IR_OE | MAR_IN, RAM_OE | A_IN, 0);

        bus.run = 1'b0; bus.opcode = 4'h0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
        #2 clr_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_quiet("reset", 0);

        // Release, remain idle with run low.
        @(negedge clk) clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check_quiet($sformatf("idle %0d", i), 0);
        end

        // Start, then execute the vector table back to back.
        @(negedge clk) bus.run = 1'b1;
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // ADD interrupted by async clear during T3.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.opcode = 4'h2; bus.run = 1'b0;
            #1 check($sformatf("ADD-abort step T%0d", c), bus.step, c);
        end
        check("ADD-abort T3 ctrl", ctrl_now(), RAM_OE | B_IN);
        #1 clr_n = 1'b0;
        #1 check_quiet("async clear", 0);
        @(negedge clk); #1 check_quiet("clear held", 0);

        // Synchronised release: first edge after release must not start.
        @(negedge clk);
        clr_n = 1'b1; bus.run = 1'b1; bus.opcode = 4'h0;
        @(negedge clk); #1 check_quiet("release edge1", 0);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ctrl_now() == F0) begin found = 1'b1; break; end
            @(negedge clk); #1;
        end
        check("restart after release", found, 1);
        bus.run = 1'b0;

        // Random opcodes (no HLT): bus drivers mutually exclusive, step bounded.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.opcode = 4'($urandom_range(0, 14));
            bus.flag_c = 1'($urandom_range(0, 1));
            bus.flag_z = 1'($urandom_range(0, 1));
            bus.run    = 1'($urandom_range(0, 1));
            #1;
            drivers = int'(bus.pc_oe) + int'(bus.ram_oe) + int'(bus.ir_oe)
                    + int'(bus.a_oe) + int'(bus.alu_oe);
            check($sformatf("one driver cyc %0d", i), (drivers <= 1), 1);
            check($sformatf("step bound cyc %0d", i), (bus.step <= 4), 1);
            assert (drivers <= 1) else $error("bus contention at cycle %0d", i);
        end

        // HLT, then run pulses must not leave HALT.
        goto_t0();
        bus.opcode = 4'hF;
        #1 check("HLT T0 ctrl", ctrl_now(), F0);
        @(negedge clk); #1 check("HLT T1 ctrl", ctrl_now(), F1);
        @(negedge clk); #1;
        check("HLT T2 ctrl", ctrl_now(), 0);
        check("HLT T2 step", bus.step, 2);
        check("HLT T2 halt", bus.halt, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.run = (i % 2 == 0);
            bus.opcode = 4'($urandom_range(0, 15));
            #1 check_quiet($sformatf("halted %0d", i), 1);
        end
        #1 clr_n = 1'b0;
        #1 check_quiet("clear from halt", 0);
        @(negedge clk) clr_n = 1'b1;
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_quiet("idle after halt clear", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (input, 1, rising-edge clock), clr_n (input, 1, async active-low reset).
REQ-002 SHALL have ports:
- run  input  1  start execution from IDLE
- opcode  input  4  IR[7:4] from instruction register
- flag_c  input  1  registered carry flag
- flag_z  input  1  registered zero flag
- pc_oe, pc_inc, pc_jmp  output  1 each  program counter output-enable / increment / load (clr tied off externally)
- mar_in  output  1  MAR load
- ram_oe, ram_we  output  1 each  RAM read-drive / write
- ir_in, ir_oe  output  1 each  IR load / operand (IR[3:0]) drive
- a_in, a_oe, b_in  output  1 each  A load, A drive, B load
- alu_oe, alu_sub  output  1 each  ALU drive, subtract select
- flags_in, out_in  output  1 each  flag register load, output register load
- halt  output  1  machine halted
- step  output  3  current T-state, debug

Function
REQ-003 SHALL implement states IDLE, RUN, HALT; step counter T0..T4 valid only in RUN.
REQ-004 IDLE: all controls 0; run=1 at a rising edge -> RUN, step=T0 next cycle; run=0 -> stay.
REQ-005 Controls SHALL be combinational decode of (state, step, opcode, flags); no added latency; at most one bus driver (pc_oe, ram_oe, ir_oe, a_oe, alu_oe) high per cycle.
REQ-006 Fetch, all opcodes: T0 pc_oe+mar_in; T1 ram_oe+ir_in+pc_inc.
REQ-007 Execute (opcode hex):
- 0 NOP: none, ends after T1
- 1 LDA: T2 ir_oe+mar_in; T3 ram_oe+a_in
- 2 ADD: T2 ir_oe+mar_in; T3 ram_oe+b_in; T4 alu_oe+a_in+flags_in
- 3 SUB: as ADD, alu_sub=1 in T4 only
- 4 STA: T2 ir_oe+mar_in; T3 a_oe+ram_we
- 5 LDI: T2 ir_oe+a_in
- 6 JMP: T2 ir_oe+pc_jmp
- 7 JC: T2 ir_oe+pc_jmp iff flag_c=1, else no controls
- 8 JZ: T2 ir_oe+pc_jmp iff flag_z=1, else no controls
- E OUT: T2 a_oe+out_in
- F HLT: T2 no controls, -> HALT
- 9..D undefined: treated as NOP
REQ-008 Step after an opcode's last listed step SHALL be T0 (variable length: NOP 2, LDI/JMP/JC/JZ/OUT 3, LDA/STA 4, ADD/SUB 5 cycles); step never exceeds T4.
REQ-009 Opcode SHALL be decoded from T2 on; opcode value during T0/T1 SHALL not affect outputs.
REQ-010 JC/JZ not taken SHALL still take 3 cycles.
REQ-011 HALT: halt=1, all other controls 0, step=0; sticky until clr_n low; run ignored.
REQ-012 run ignored while in RUN.

Reset
REQ-013 clr_n=0 SHALL immediately (async) force state IDLE, step=0, all outputs 0, including mid-instruction.
REQ-014 Release of clr_n SHALL be synchronised; first transition earliest at second rising clk after deassertion.

Structure
REQ-015 Shared package SHALL hold opcode constants (OP_NOP..OP_HLT), state encoding, step width/values and control-bit indices.
REQ-016 Registered state/step SHALL live in control_sequencer; combinational microcode decode SHALL be sub-module control_decode.

Verification
REQ-017 Reset then run=1 one cycle, opcode=1 -> T0 pc_oe+mar_in, T1 ram_oe+ir_in+pc_inc, T2 ir_oe+mar_in, T3 ram_oe+a_in, then T0.
REQ-018 opcode=3 -> five cycles, alu_sub=1 and flags_in=1 only in T4, step returns to 0.
REQ-019 opcode=7 with flag_c=0 -> T2 all zero; repeat with flag_c=1 -> T2 ir_oe+pc_jmp=1; both 3 cycles.
REQ-020 opcode=F -> halt=1 from cycle after T2; run pulses for 10 cycles -> halt stays 1, all controls 0.
REQ-021 clr_n=0 asynchronously during ADD T3 -> outputs 0 before next edge, state IDLE, step=0.
REQ-022 Every cycle, random opcodes -> assertion: at most one bus driver high; opcode=B behaves as NOP (2 cycles).
